r16_wd_sched: RTL
=================

R16_WD_SCHED -- requirements
Module: r16_wd_sched

Interface
REQ-001 The block SHALL have parameter LAT, default 21: latency in cycles of the twiddle/data delay line it sequences.
REQ-002 The block SHALL have parameter GROUPS, default 4096: beats per radix-16 stage.
REQ-003 The block SHALL have parameter STAGES, default 4: radix-16 stages per 65536-point transform.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port start  input  1  transform request, sampled only in IDLE.
REQ-007 The block SHALL have port hold  input  1  pauses beat issue while high.
REQ-008 The block SHALL have port busy  output  1  high in ISSUE or DRAIN.
REQ-009 The block SHALL have port issue_valid  output  1  beat is presented to the delay line this cycle.
REQ-010 The block SHALL have port issue_stage  output  clog2(STAGES)  stage index of the current beat.
REQ-011 The block SHALL have port issue_grp  output  clog2(GROUPS)  group index of the current beat.
REQ-012 The block SHALL have port out_valid  output  1  delayed beat is present at the delay-line output.
REQ-013 The block SHALL have port out_stage  output  clog2(STAGES)  issue_stage delayed by LAT cycles.
REQ-014 The block SHALL have port out_grp  output  clog2(GROUPS)  issue_grp delayed by LAT cycles.
REQ-015 The block SHALL have port out_last  output  1  the final beat of the transform is at the output.
REQ-016 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ISSUE and DRAIN.
REQ-018 In IDLE, start=1 at an edge SHALL clear the stage and group counters and move the FSM to ISSUE.
REQ-019 In ISSUE or DRAIN, start SHALL be ignored and SHALL not be queued.
REQ-020 issue_valid SHALL be combinational and equal (state==ISSUE) & ~hold.
REQ-021 issue_stage and issue_grp SHALL be driven directly from the registered counters.
REQ-022 When the first cycle after start is ISSUE with hold=0, issue_valid SHALL be 1 in that cycle with stage=0 and grp=0.
REQ-023 Each issued beat SHALL advance grp by 1; when grp=GROUPS-1, grp SHALL wrap to 0 and stage SHALL increment.
REQ-024 With hold=1, issue_valid SHALL be 0 and the counters SHALL be frozen; there SHALL be no limit on hold length.
REQ-025 Issuing the beat with stage=STAGES-1 and grp=GROUPS-1 SHALL move the FSM to DRAIN; stage SHALL not wrap to 0.
REQ-026 A LAT-deep shift register SHALL carry {issue_valid, issue_stage, issue_grp} and advance every cycle regardless of hold, matching the free-running delay line.
REQ-027 The shift-register output SHALL drive out_valid, out_stage and out_grp, exactly LAT cycles after the corresponding issue cycle.
REQ-028 Holes created by hold SHALL appear unchanged at the output, delayed by LAT cycles.
REQ-029 When out_valid=0, out_stage and out_grp SHALL be 0.
REQ-030 out_last SHALL equal out_valid & (out_stage==STAGES-1) & (out_grp==GROUPS-1).
REQ-031 In DRAIN, the edge at which out_last=1 SHALL move the FSM to IDLE.
REQ-032 done SHALL be registered and equal 1 in the cycle after out_last, only.
REQ-033 busy SHALL be 0 in the done cycle.
REQ-034 start=1 in the done cycle SHALL be accepted, so back-to-back transforms are supported.
REQ-035 hold SHALL have no effect in IDLE or DRAIN.
REQ-036 With hold=0 throughout, the transform SHALL take STAGES*GROUPS issue cycles plus LAT cycles to the last out_valid; done SHALL follow one cycle later.

Reset
REQ-037 rst=1 at an edge SHALL force IDLE, zero the counters, clear every shift-register entry and set done=0.
REQ-038 After reset, busy, issue_valid, out_valid, out_last and done SHALL all be 0.
REQ-039 rst SHALL take priority over start and hold at the same edge.
REQ-040 After a reset taken mid-transform, no out_valid SHALL appear from beats issued before the reset.

Verification
REQ-041 Defaults, start pulse, hold=0: first issue_valid 1 cycle after start; first out_valid 21 cycles later with stage0/grp0; 65536 out_valid beats; out_last with stage3/grp4095; done one cycle later.
REQ-042 LAT=3, GROUPS=4, STAGES=2, hold=1 for 5 cycles after the 2nd beat: grp sequence 0,1,[5-cycle gap],2,3 then stage1; output shows the identical gap 3 cycles later; 8 beats total.
REQ-043 Wrap check, GROUPS=4: beat after stage0/grp3 is stage1/grp0; no repeated or skipped index.
REQ-044 start asserted during ISSUE and DRAIN: no restart, counters undisturbed; start in the done cycle: new transform begins with stage0/grp0 in the next cycle.
REQ-045 rst at beat 100 of a default run: all outputs 0 at the next cycle; no out_valid for the following 21 cycles; a fresh start then runs to completion normally.
REQ-046 rst and start asserted at the same edge: the block remains in IDLE with busy=0.

Source files
------------

// File: rtl/r16_wd_sched.sv
// Radix-16 FFT twiddle/data scheduler: issues stage/group beats
// and tracks them through a fixed-latency delay line.
module r16_wd_sched #(
  parameter  int LAT    = 21,
  parameter  int GROUPS = 4096,
  parameter  int STAGES = 4,
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          issue_valid,
  output logic [SW-1:0] issue_stage,
  output logic [GW-1:0] issue_grp,
  output logic          out_valid,
  output logic [SW-1:0] out_stage,
  output logic [GW-1:0] out_grp,
  output logic          out_last,
  output logic          done
);

  localparam int W = 1 + SW + GW;
  localparam logic [SW-1:0] S_LAST = SW'(STAGES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          done_q;
  logic [W-1:0]  sr_q [LAT];
  logic [W-1:0]  sr_in;
  logic          last_beat;

  assign busy        = (state_q != IDLE);
  assign issue_valid = (state_q == ISSUE) & ~hold;
  assign issue_stage = stage_q;
  assign issue_grp   = grp_q;
  assign last_beat   = issue_valid & (stage_q == S_LAST)
                     & (grp_q == G_LAST);

  // Idle slots enter the delay line as all-zero words
  assign sr_in = issue_valid ? {1'b1, stage_q, grp_q} : '0;

  assign {out_valid, out_stage, out_grp} = sr_q[LAT-1];
  assign out_last = out_valid & (out_stage == S_LAST)
                  & (out_grp == G_LAST);
  assign done     = done_q;

  // Next-state and counter advance
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    grp_d   = grp_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stage_d = '0;
          grp_d   = '0;
        end
      end
      ISSUE: begin
        if (last_beat) begin
          state_d = DRAIN;
        end else if (issue_valid) begin
          if (grp_q == G_LAST) begin
            grp_d   = '0;
            stage_d = stage_q + 1'b1;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, done pulse and free-running delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      grp_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      grp_q   <= grp_d;
      done_q  <= out_last;
      sr_q[0] <= sr_in;
      for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end

endmodule
